// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: default word width and the ReLU-backward
// tile sequencing states.
package cnn_pkg;

  localparam int CNN_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } relu_bwd_state_t;

endpackage

// File: rtl/relu_backward_if.sv
// Stream bundle for relu_backward: forward pre-activations in, upstream
// gradients in, gated gradients out, each with valid/ready.
interface relu_backward_if
  import cnn_pkg::*;
#(
  parameter int DATA_W = CNN_DATA_W
) ();

  logic              fwd_valid;
  logic              fwd_ready;
  logic [DATA_W-1:0] fwd_data;
  logic              fwd_last;

  logic              grad_in_valid;
  logic              grad_in_ready;
  logic [DATA_W-1:0] grad_in;

  logic              grad_out_valid;
  logic              grad_out_ready;
  logic [DATA_W-1:0] grad_out;
  logic              grad_out_last;

  modport master (
    output fwd_valid, fwd_data, fwd_last,
    output grad_in_valid, grad_in,
    output grad_out_ready,
    input  fwd_ready, grad_in_ready,
    input  grad_out_valid, grad_out, grad_out_last
  );

  modport slave (
    input  fwd_valid, fwd_data, fwd_last,
    input  grad_in_valid, grad_in,
    input  grad_out_ready,
    output fwd_ready, grad_in_ready,
    output grad_out_valid, grad_out, grad_out_last
  );

endinterface

// File: rtl/relu_mask_buf.sv
// DEPTH x 1-bit ReLU mask store: synchronous write, combinational read, so it
// maps onto distributed RAM.
module relu_mask_buf #(
  parameter int DEPTH = 256,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wbit,
  input  logic [AW-1:0] raddr,
  output logic          rbit
);

  logic mem_q [DEPTH];

  // NOTE: no reset on the storage array; every entry read in a tile is
  // written earlier in that same tile, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wbit;
  end

  assign rbit = mem_q[raddr];

endmodule

// File: rtl/relu_backward.sv
// ReLU backward stage: captures a tile of positive/non-positive mask bits from
// the forward pass, then gates the upstream gradient stream with them.
module relu_backward
  import cnn_pkg::*;
#(
  parameter int DATA_W = CNN_DATA_W,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  relu_backward_if.slave   bus,
  output logic [CNT_W-1:0] dead_count,
  output logic             tile_trunc
);

  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  relu_bwd_state_t   state_q, state_d;
  logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  dead_q, dead_d;
  logic              trunc_q, trunc_d;
  logic [DATA_W-1:0] gout_q, gout_d;
  logic              gout_valid_q, gout_valid_d;
  logic              gout_last_q, gout_last_d;

  logic fwd_ready, grad_in_ready;
  logic fwd_acc, grad_acc, out_done;
  logic fwd_pos, mask_rbit;

  // Strictly positive in two's complement: sign bit clear and not all zeros.
  assign fwd_pos       = !bus.fwd_data[DATA_W-1] && (|bus.fwd_data);
  assign fwd_ready     = (state_q == IDLE) || (state_q == CAPTURE);
  assign grad_in_ready = (state_q == DRAIN) && (rd_ptr_q < wr_ptr_q) &&
                         (!gout_valid_q || bus.grad_out_ready);
  assign fwd_acc       = bus.fwd_valid && fwd_ready;
  assign grad_acc      = bus.grad_in_valid && grad_in_ready;
  assign out_done      = gout_valid_q && bus.grad_out_ready && gout_last_q;

  relu_mask_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mask_buf (
    .clk   (clk),
    .we    (fwd_acc),
    .waddr (wr_ptr_q[AW-1:0]),
    .wbit  (fwd_pos),
    .raddr (rd_ptr_q[AW-1:0]),
    .rbit  (mask_rbit)
  );

  // NOTE: every signal written here gets its default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    dead_d       = dead_q;
    trunc_d      = trunc_q;
    gout_d       = gout_q;
    gout_valid_d = gout_valid_q;
    gout_last_d  = gout_last_q;

    unique case (state_q)
      IDLE, CAPTURE: begin
        if (fwd_acc) begin
          wr_ptr_d = wr_ptr_q + ONE;
          if (!fwd_pos && (dead_q != DEPTH_C)) dead_d = dead_q + ONE;
          if (bus.fwd_last) begin
            state_d = DRAIN;
          end else if (wr_ptr_d == DEPTH_C) begin
            state_d = DRAIN;
            trunc_d = 1'b1;
          end else begin
            state_d = CAPTURE;
          end
        end
      end
      DRAIN: begin
        if (grad_acc) begin
          gout_d       = mask_rbit ? bus.grad_in : '0;
          gout_valid_d = 1'b1;
          gout_last_d  = (rd_ptr_q == (wr_ptr_q - ONE));
          rd_ptr_d     = rd_ptr_q + ONE;
        end else if (bus.grad_out_ready) begin
          gout_valid_d = 1'b0;
          gout_last_d  = 1'b0;
        end
        // The final beat leaves with rd_ptr == wr_ptr, so no gradient can be
        // accepted in the same cycle as the exit.
        if (out_done) begin
          state_d  = IDLE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          dead_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      dead_q       <= '0;
      trunc_q      <= 1'b0;
      gout_q       <= '0;
      gout_valid_q <= 1'b0;
      gout_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      dead_q       <= dead_d;
      trunc_q      <= trunc_d;
      gout_q       <= gout_d;
      gout_valid_q <= gout_valid_d;
      gout_last_q  <= gout_last_d;
    end
  end

  assign bus.fwd_ready      = fwd_ready;
  assign bus.grad_in_ready  = grad_in_ready;
  assign bus.grad_out_valid = gout_valid_q;
  assign bus.grad_out       = gout_q;
  assign bus.grad_out_last  = gout_last_q;
  assign dead_count         = dead_q;
  assign tile_trunc         = trunc_q;

endmodule

// File: tb/tb_relu_backward.sv
// Scenario bench for relu_backward: a mask model fills an expected-beat queue
// as gradients are accepted; observed output beats are compared in order.
module tb_relu_backward;
  import cnn_pkg::*;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 256;
  localparam int CNT_W  = 9;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] dead_count;
  logic             tile_trunc;

  relu_backward_if #(.DATA_W(DATA_W)) bus ();

  relu_backward #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dead_count (dead_count),
    .tile_trunc (tile_trunc)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  bit    mask_q[$];
  beat_t exp_q[$];
  beat_t obs_q[$];
  int    obs_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: inputs only change at negedge, so 2 units later the
  // handshake for the coming posedge is settled.
  always @(negedge clk) begin
    #2;
    if (!rst && bus.grad_out_valid && bus.grad_out_ready) begin
      obs_q.push_back({bus.grad_out_last, bus.grad_out});
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fwd_word(input logic [DATA_W-1:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    bus.fwd_valid = 1'b1;
    bus.fwd_data  = d;
    bus.fwd_last  = last;
    #1;
    while (!bus.fwd_ready && n < 200) begin @(negedge clk); #1; n++; end
    if (!bus.fwd_ready) begin
      checks++; errors++;
      $display("FAIL fwd_timeout: fwd_ready=%0b required 1", bus.fwd_ready);
      bus.fwd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    mask_q.push_back($signed(d) > 0);
    #1 bus.fwd_valid = 1'b0;
  endtask

  task automatic grad_word(input logic [DATA_W-1:0] g);
    int    n = 0;
    bit    m;
    beat_t b;
    @(negedge clk);
    bus.grad_in_valid = 1'b1;
    bus.grad_in       = g;
    #1;
    while (!bus.grad_in_ready && n < 200) begin @(negedge clk); #1; n++; end
    if (!bus.grad_in_ready || mask_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL grad_accept: grad_in_ready=%0b pending_masks=%0d", bus.grad_in_ready, mask_q.size());
      bus.grad_in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    m      = mask_q.pop_front();
    b.data = m ? g : '0;
    b.last = (mask_q.size() == 0);
    exp_q.push_back(b);
    #1 bus.grad_in_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int t = 0;
    while (obs_q.size() < n && t < 1000) begin @(negedge clk); t++; end
    if (obs_q.size() < n) begin
      checks++; errors++;
      $display("FAIL out_timeout: got %0d beats required %0d", obs_q.size(), n);
    end
  endtask

  task automatic clear_sb();
    mask_q.delete();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.fwd_ready !== 1'b1) begin errors++; $display("FAIL rst_fwd_ready: got %0b required 1", bus.fwd_ready); end
    checks++; if (bus.grad_in_ready !== 1'b0) begin errors++; $display("FAIL rst_grad_in_ready: got %0b required 0", bus.grad_in_ready); end
    checks++; if (bus.grad_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b required 0", bus.grad_out_valid); end
    checks++; if (bus.grad_out !== '0) begin errors++; $display("FAIL rst_grad_out: got %h required 0000", bus.grad_out); end
    checks++; if (bus.grad_out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %0b required 0", bus.grad_out_last); end
    checks++; if (dead_count !== '0) begin errors++; $display("FAIL rst_dead: got %0d required 0", dead_count); end
    checks++; if (tile_trunc !== 1'b0) begin errors++; $display("FAIL rst_trunc: got %0b required 0", tile_trunc); end
  endtask

  task automatic test_basic_tile();
    logic [DATA_W-1:0] fd [4];
    logic [DATA_W-1:0] gd [4];
    beat_t e, o;
    fd = '{16'd5, 16'hFFFD, 16'd0, 16'h7FFF};
    gd = '{16'd10, 16'd20, 16'd30, 16'd40};
    clear_sb();
    bus.grad_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) fwd_word(fd[i], i == 3);
    checks++; if (dead_count !== 9'd2) begin errors++; $display("FAIL basic_dead: got %0d required 2", dead_count); end
    checks++; if (bus.fwd_ready !== 1'b0) begin errors++; $display("FAIL basic_drain_fwd_ready: got %0b required 0", bus.fwd_ready); end
    for (int i = 0; i < 4; i++) grad_word(gd[i]);
    wait_outputs(4);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL basic_beat: got %h/%0b required %h/%0b", o.data, o.last, e.data, e.last); end
    end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.fwd_ready !== 1'b1) begin errors++; $display("FAIL basic_idle: fwd_ready=%0b required 1", bus.fwd_ready); end
    checks++; if (dead_count !== '0) begin errors++; $display("FAIL basic_dead_clear: got %0d required 0", dead_count); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] fd [6];
    logic [DATA_W-1:0] held;
    logic              held_last;
    beat_t e, o;
    fd = '{16'd3, 16'hFFFC, 16'd8, 16'd1, 16'd0, 16'd12};
    clear_sb();
    bus.grad_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) fwd_word(fd[i], i == 5);
    fork
      for (int i = 0; i < 6; i++) grad_word(16'h0100 + 16'(i));
      begin
        int t = 0;
        while (obs_q.size() < 2 && t < 100) begin @(negedge clk); t++; end
        bus.grad_out_ready = 1'b0;
        #3;
        held      = bus.grad_out;
        held_last = bus.grad_out_last;
        checks++; if (bus.grad_out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %0b required 1", bus.grad_out_valid); end
        repeat (3) begin
          @(negedge clk); #3;
          checks++; if ({bus.grad_out_last, bus.grad_out} !== {held_last, held}) begin errors++; $display("FAIL bp_stable: got %h required %h", bus.grad_out, held); end
          checks++; if (bus.grad_in_ready !== 1'b0) begin errors++; $display("FAIL bp_grad_in_ready: got %0b required 0", bus.grad_in_ready); end
        end
        @(negedge clk);
        bus.grad_out_ready = 1'b1;
      end
    join
    wait_outputs(6);
    checks++; if (obs_cyc.size() < 6 || obs_cyc[1] - obs_cyc[0] != 1) begin errors++; $display("FAIL bp_rate_pre: beats %0d not one per cycle before stall", obs_cyc.size()); end
    for (int i = 2; i < 5 && i + 1 < obs_cyc.size(); i++) begin
      checks++; if (obs_cyc[i+1] - obs_cyc[i] != 1) begin errors++; $display("FAIL bp_rate: beat %0d gap %0d required 1", i + 1, obs_cyc[i+1] - obs_cyc[i]); end
    end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL bp_beat: got %h/%0b required %h/%0b", o.data, o.last, e.data, e.last); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_overflow();
    beat_t e, o;
    clear_sb();
    bus.grad_out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_word(16'd1, 1'b0);
      if (i == DEPTH - 2) begin
        checks++; if (tile_trunc !== 1'b0 || bus.fwd_ready !== 1'b1) begin errors++; $display("FAIL ovf_early: trunc=%0b fwd_ready=%0b required 0/1", tile_trunc, bus.fwd_ready); end
      end
    end
    checks++; if (tile_trunc !== 1'b1) begin errors++; $display("FAIL ovf_trunc: got %0b required 1", tile_trunc); end
    checks++; if (bus.fwd_ready !== 1'b0) begin errors++; $display("FAIL ovf_drain: fwd_ready=%0b required 0", bus.fwd_ready); end
    checks++; if (dead_count !== '0) begin errors++; $display("FAIL ovf_dead: got %0d required 0", dead_count); end
    for (int i = 0; i < DEPTH; i++) grad_word(16'(i * 257 + 3));
    wait_outputs(DEPTH);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL ovf_beat: got %h/%0b required %h/%0b", o.data, o.last, e.data, e.last); end
    end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (tile_trunc !== 1'b1 || bus.fwd_ready !== 1'b1) begin errors++; $display("FAIL ovf_after: trunc=%0b fwd_ready=%0b required 1/1", tile_trunc, bus.fwd_ready); end
  endtask

  task automatic test_ordering();
    beat_t e, o;
    clear_sb();
    bus.grad_out_ready = 1'b1;
    fwd_word(16'hFFF9, 1'b0);
    fwd_word(16'd9, 1'b0);
    fork
      grad_word(16'h1111);
      begin
        repeat (3) begin
          @(negedge clk); #1;
          checks++; if (bus.grad_in_ready !== 1'b0) begin errors++; $display("FAIL ord_capture_grad_ready: got %0b required 0", bus.grad_in_ready); end
        end
        fwd_word(16'd1, 1'b1);
      end
    join
    @(negedge clk);
    bus.fwd_valid = 1'b1;
    bus.fwd_data  = 16'd5;
    bus.fwd_last  = 1'b1;
    #1;
    checks++; if (bus.fwd_ready !== 1'b0) begin errors++; $display("FAIL ord_drain_fwd_ready: got %0b required 0", bus.fwd_ready); end
    @(negedge clk);
    bus.fwd_valid = 1'b0;
    #1;
    checks++; if (dead_count !== 9'd1) begin errors++; $display("FAIL ord_dead: got %0d required 1", dead_count); end
    grad_word(16'h2222);
    grad_word(16'h3333);
    wait_outputs(3);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ord_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL ord_beat: got %h/%0b required %h/%0b", o.data, o.last, e.data, e.last); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_drain();
    beat_t e, o;
    clear_sb();
    bus.grad_out_ready = 1'b1;
    fwd_word(16'd1, 1'b0);
    fwd_word(16'd2, 1'b0);
    fwd_word(16'hFFFD, 1'b0);
    fwd_word(16'd4, 1'b1);
    grad_word(16'h000A);
    grad_word(16'h000B);
    wait_outputs(2);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL rmd_pre_beat: got %h/%0b required %h/%0b", o.data, o.last, e.data, e.last); end
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if ({bus.grad_out_valid, bus.grad_out_last, bus.grad_out} !== '0) begin errors++; $display("FAIL rmd_outputs: valid=%0b last=%0b data=%h required 0", bus.grad_out_valid, bus.grad_out_last, bus.grad_out); end
    checks++; if (dead_count !== '0 || tile_trunc !== 1'b0) begin errors++; $display("FAIL rmd_status: dead=%0d trunc=%0b required 0/0", dead_count, tile_trunc); end
    checks++; if (bus.fwd_ready !== 1'b1 || bus.grad_in_ready !== 1'b0) begin errors++; $display("FAIL rmd_ready: fwd=%0b grad=%0b required 1/0", bus.fwd_ready, bus.grad_in_ready); end
    rst = 1'b0;
    clear_sb();
    fwd_word(16'hFFFF, 1'b1);
    checks++; if (dead_count !== 9'd1) begin errors++; $display("FAIL rmd_dead: got %0d required 1", dead_count); end
    grad_word(16'd7);
    wait_outputs(1);
    checks++; if (obs_q.size() != 1 || exp_q.size() != 1) begin errors++; $display("FAIL rmd_count: got %0d required 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL rmd_beat: got %h/%0b required %h/%0b", o.data, o.last, e.data, e.last); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_min();
    beat_t e, o;
    clear_sb();
    bus.grad_out_ready = 1'b1;
    fwd_word(16'h8000, 1'b1);
    checks++; if (dead_count !== 9'd1) begin errors++; $display("FAIL single_dead: got %0d required 1", dead_count); end
    grad_word(16'h1234);
    wait_outputs(1);
    checks++; if (obs_q.size() != 1 || exp_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d required 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL single_beat: got %h/%0b required %h/%0b", o.data, o.last, e.data, e.last); end
    end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.fwd_ready !== 1'b1) begin errors++; $display("FAIL single_idle: fwd_ready=%0b required 1", bus.fwd_ready); end
  endtask

  initial begin
    bus.fwd_valid      = 1'b0;
    bus.fwd_data       = '0;
    bus.fwd_last       = 1'b0;
    bus.grad_in_valid  = 1'b0;
    bus.grad_in        = '0;
    bus.grad_out_ready = 1'b0;
    test_reset();
    test_basic_tile();
    test_backpressure();
    test_ordering();
    test_overflow();
    test_reset_mid_drain();
    test_single_min();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
